// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, round constants,
// key-schedule steps and the decryption FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_OUT
  } aes_state_t;

  // Entry 0 and entries above 10 are never used by AES-128.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover rk_r from rk_{r+1} using rcon[r+1].
  function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  // Products by {0e, 0b, 0d, 09} packed MSB first, built from one xtime chain.
  function automatic logic [31:0] inv_mul_set(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [31:0] p0, p1, p2, p3;
    p0 = inv_mul_set(col[31:24]);
    p1 = inv_mul_set(col[23:16]);
    p2 = inv_mul_set(col[15:8]);
    p3 = inv_mul_set(col[7:0]);
    return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
            p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
            p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
            p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
  endfunction

  logic [127:0] sub_ark;

  // Byte (row r, column c) sits at index 4*c + r; row r rotates right by r.
  always_comb begin
    sub_ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_ark[127 - 8*(4*c + r) -: 8] =
          inv_sbox(state_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]) ^
          round_key[127 - 8*(4*c + r) -: 8];
      end
    end
  end

  always_comb begin
    state_out = sub_ark;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        state_out[127 - 32*c -: 32] = inv_mix_col(sub_ark[127 - 32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryptor, bytes in/out MSB first; optional rk10 cache via AES_DEC_KEY_CACHE_EN.
// Latency: ready 22 cycles after the 16th input byte (12 when the cached round key is reused).
// Backpressure: enable=0 pauses loading and holds state_out_byte stable while ready=1.
module aes_decryption
  import aes_pkg::*;
#(
  parameter int NR       = 10,
  parameter int NB_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] key_byte,
  input  logic [7:0] state_byte,
`ifdef AES_DEC_KEY_CACHE_EN
  input  logic       key_reuse,
`endif
  output logic [7:0] state_out_byte,
  output logic       load,
  output logic       ready,
  output logic       busy
);

  if (NR != 10 || NB_BYTES != 16) begin : g_bad_cfg
    $error("aes_decryption supports only AES-128 (NR=10, NB_BYTES=16)");
  end

  localparam logic [3:0] LAST_IDX  = 4'(NB_BYTES - 1);
  localparam logic [3:0] LAST_KEXP = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  aes_state_t   st_q, st_d;
  logic [3:0]   cnt_q, rnd_q;
  logic [127:0] key_q, state_q;
  logic [7:0]   out_q;
  logic [127:0] key_fwd, rk_prev, round_out, key_cached;
  logic         last_byte, skip_kexp, zero_key;

  assign last_byte = (cnt_q == LAST_IDX);
  assign key_fwd   = key_step_fwd(key_q, RCON[rnd_q]);
  assign rk_prev   = key_step_inv(key_q, RCON[rnd_q + 4'd1]);

  aes_inv_round u_inv_round (
    .state_in  (state_q),
    .round_key (rk_prev),
    .last      (rnd_q == 4'd0),
    .state_out (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_q;
  logic         cache_vld_q, reuse_q, reuse_now;

  // key_reuse counts only on the first byte of a block; later bytes use the latched flag.
  assign reuse_now  = (st_q == ST_IDLE) ? key_reuse : reuse_q;
  assign zero_key   = reuse_now;
  assign skip_kexp  = reuse_now & cache_vld_q;
  assign key_cached = cache_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      reuse_q     <= 1'b0;
    end else begin
      if (st_q == ST_IDLE && enable) reuse_q <= key_reuse;
      if (st_q == ST_KEYEXP && rnd_q == LAST_KEXP) begin
        cache_q     <= key_fwd;
        cache_vld_q <= 1'b1;
      end
    end
  end
`else
  assign zero_key   = 1'b0;
  assign skip_kexp  = 1'b0;
  assign key_cached = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= ST_IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:   if (enable) st_d = ST_LOAD;
      ST_LOAD:   if (enable && last_byte) st_d = skip_kexp ? ST_INIT : ST_KEYEXP;
      ST_KEYEXP: if (rnd_q == LAST_KEXP) st_d = ST_INIT;
      ST_INIT:   st_d = ST_ROUND;
      ST_ROUND:  if (rnd_q == 4'd0) st_d = ST_OUT;
      ST_OUT:    if (enable && last_byte) st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    ready = 1'b0;
    busy  = 1'b0;
    case (st_q)
      ST_IDLE, ST_LOAD:             load  = 1'b1;
      ST_KEYEXP, ST_INIT, ST_ROUND: busy  = 1'b1;
      ST_OUT:                       ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rnd_q   <= '0;
      key_q   <= '0;
      state_q <= '0;
      out_q   <= '0;
    end else begin
      case (st_q)
        ST_IDLE, ST_LOAD: begin
          if (enable) begin
            key_q   <= {key_q[119:0], zero_key ? 8'h00 : key_byte};
            state_q <= {state_q[119:0], state_byte};
            cnt_q   <= cnt_q + 4'd1;
            if (last_byte) begin
              rnd_q <= skip_kexp ? FIRST_RND : 4'd1;
              if (skip_kexp) key_q <= key_cached;
            end
          end
        end
        ST_KEYEXP: begin
          key_q <= key_fwd;
          rnd_q <= (rnd_q == LAST_KEXP) ? FIRST_RND : rnd_q + 4'd1;
        end
        ST_INIT: state_q <= state_q ^ key_q;
        ST_ROUND: begin
          key_q   <= rk_prev;
          state_q <= round_out;
          if (rnd_q == 4'd0) out_q <= round_out[127:120];
          else               rnd_q <= rnd_q - 4'd1;
        end
        ST_OUT: begin
          // Shift the plaintext up so the next byte is always at the top.
          if (enable) begin
            state_q <= {state_q[119:0], 8'h00};
            out_q   <= state_q[119:112];
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_out_byte = out_q;

endmodule
